// File: rtl/device_alu.sv
// Registered 4-bit add/sub/mul/div unit with 8-bit result and divide-by-zero flag.
// Build option: define DEVICE_ALU_REM_EN to place the remainder in out_data[7:4] on divide.
module device_alu (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [1:0] opcode,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       div_by_zero
);

  localparam int unsigned IW = 4;
  localparam int unsigned OW = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  logic [OW-1:0] a_ext;
  logic [OW-1:0] b_ext;
  logic [OW-1:0] result_c;
  logic          dbz_c;
  logic [IW-1:0] quot_c;
`ifdef DEVICE_ALU_REM_EN
  logic [IW-1:0] rem_c;
`endif

  assign a_ext = OW'(in1);
  assign b_ext = OW'(in2);

  // Next result from the current operands; wraps to 8 bits on subtract underflow.
  always_comb begin
    result_c = '0;
    dbz_c    = 1'b0;
    quot_c   = '0;
`ifdef DEVICE_ALU_REM_EN
    rem_c    = '0;
`endif
    case (op_e'(opcode))
      OP_ADD: result_c = a_ext + b_ext;
      OP_SUB: result_c = a_ext - b_ext;
      OP_MUL: result_c = a_ext * b_ext;
      OP_DIV: begin
        if (in2 == '0) begin
          result_c = '1;
          dbz_c    = 1'b1;
        end else begin
          quot_c = in1 / in2;
`ifdef DEVICE_ALU_REM_EN
          rem_c    = in1 % in2;
          result_c = {rem_c, quot_c};
`else
          result_c = {IW'(0), quot_c};
`endif
        end
      end
      default: result_c = '0;
    endcase
  end

  // Output registers; data and flag hold while no operand is strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data    <= result_c;
        div_by_zero <= dbz_c;
      end
    end
  end

endmodule

// File: tb/tb_device_alu.sv
// Self-checking bench for device_alu: directed plan steps then randomized ops vs. an arithmetic model.
module tb_device_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [1:0] opcode;
  logic [7:0] out_data;
  logic       out_valid;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_dbz   = 1'b0;

  always #5 clk = ~clk;

  device_alu device (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in1        (in1),
    .in2        (in2),
    .opcode     (opcode),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .div_by_zero(div_by_zero)
  );

  function automatic logic [7:0] model(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      default: begin
        if (b == 0) r = 255;
        else begin
          r = a / b;
`ifdef DEVICE_ALU_REM_EN
          r = r + 16 * (a % b);
`endif
        end
      end
    endcase
    return 8'(r);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the expectation and compare all outputs.
  task automatic step(input string tag, input logic r, input logic v,
                      input int a, input int b, input int op);
    rst      = r;
    in_valid = v;
    in1      = 4'(a);
    in2      = 4'(b);
    opcode   = 2'(op);
    @(posedge clk);
    #1;
    if (r) begin
      exp_data  = 8'h00;
      exp_valid = 1'b0;
      exp_dbz   = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        exp_data = model(a, b, op);
        exp_dbz  = (op == 3) && (b == 0);
      end
    end
    check({tag, ".data"},  out_data, exp_data);
    check({tag, ".valid"}, 8'(out_valid), 8'(exp_valid));
    check({tag, ".dbz"},   8'(div_by_zero), 8'(exp_dbz));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; opcode = '0;
    step("reset0", 1'b1, 1'b0, 0, 0, 0);
    step("reset1", 1'b1, 1'b0, 0, 0, 0);
    check("reset_data_const", out_data, 8'h00);

    step("add",     1'b0, 1'b1, 2, 3, 0);
    check("add_lit", out_data, 8'd5);
    step("idle",    1'b0, 1'b0, 0, 0, 0);
    step("sub_pos", 1'b0, 1'b1, 5, 3, 1);
    step("sub_neg", 1'b0, 1'b1, 3, 5, 1);
    check("sub_neg_lit", out_data, 8'hFE);
    step("mul",     1'b0, 1'b1, 2, 3, 2);
    step("mul_max", 1'b0, 1'b1, 15, 15, 2);
    check("mul_max_lit", out_data, 8'd225);
    step("div",     1'b0, 1'b1, 6, 3, 3);
    step("div_rem", 1'b0, 1'b1, 7, 2, 3);
`ifdef DEVICE_ALU_REM_EN
    check("div_rem_lit", out_data, 8'h13);
`else
    check("div_rem_lit", out_data, 8'h03);
`endif
    step("div_zero", 1'b0, 1'b1, 9, 0, 3);
    check("div_zero_flag", 8'(div_by_zero), 8'h01);
    step("dz_hold",  1'b0, 1'b0, 4, 4, 0);
    step("dz_clear", 1'b0, 1'b1, 1, 1, 0);

    // Back-to-back, then hold with changing operands, then reset racing a valid op.
    step("b2b0", 1'b0, 1'b1, 4, 5, 0);
    step("b2b1", 1'b0, 1'b1, 1, 9, 1);
    step("b2b2", 1'b0, 1'b1, 7, 6, 2);
    step("b2b3", 1'b0, 1'b1, 15, 4, 3);
    step("hold0", 1'b0, 1'b0, 11, 0, 3);
    step("hold1", 1'b0, 1'b0, 2, 13, 2);
    step("pre_rst", 1'b0, 1'b1, 9, 0, 3);
    step("rst_vs_valid", 1'b1, 1'b1, 8, 8, 2);
    step("post_rst", 1'b0, 1'b0, 3, 3, 0);

    for (int i = 0; i < 300; i++) begin
      logic r;
      logic v;
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      step("rand", r, v, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/device_alu.md
# device_alu

Small registered 4-bit arithmetic unit, instantiated in the design as `device`. It takes two unsigned 4-bit operands and a 2-bit opcode and produces an 8-bit result one clock after the operands are accepted. Operations are add, subtract, multiply and divide. It is a leaf datapath block with a simple valid strobe and no back-pressure.

## Interface
Parameters:
- None. All widths are fixed.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand strobe; operands are sampled on an edge where it is 1.
- `in1` in 4: operand A, unsigned.
- `in2` in 4: operand B, unsigned.
- `opcode` in 2: operation select.
  - 00 = add
  - 01 = subtract
  - 10 = multiply
  - 11 = divide
- `out_data` out 8: registered result.
- `out_valid` out 1: 1-cycle pulse marking a new `out_data`.
- `div_by_zero` out 1: registered error flag for the result in `out_data`.

## Operation
- Arithmetic is carried out at 8 bits with both operands zero-extended.
- Add: `out_data = in1 + in2`. Range 0..30, so no overflow is possible.
- Subtract: `out_data = in1 - in2` as 8-bit two's complement.
  - A negative result is sign-extended, e.g. 3-5 = 8'hFE.
- Multiply: `out_data = in1 * in2`. Range 0..225, so no overflow is possible.
- Divide, `in2 != 0`:
  - Quotient = `in1 / in2`, truncated toward zero.
  - Placement of the quotient and remainder is set by the Configuration section.
- Divide, `in2 == 0`:
  - `out_data = 8'hFF`.
  - `div_by_zero = 1`.
- `div_by_zero` is 0 for every result other than divide-by-zero.
- `div_by_zero` updates together with `out_data` and holds with it.
- When `in_valid = 0`, `out_data` and `div_by_zero` hold their last values and `out_valid` is 0.
- There is no internal state beyond the output registers. No FSM.

## Timing
- Latency is 1 cycle.
  - Operands sampled at edge N appear on `out_data` after edge N.
  - `out_valid = 1` during cycle N+1.
- Throughput is one operation per cycle.
  - Back-to-back `in_valid` gives back-to-back `out_valid` pulses.
- Reset values, applied at a rising edge with `rst = 1`:
  - `out_data = 8'h00`
  - `out_valid = 0`
  - `div_by_zero = 0`
- Reset takes priority over `in_valid` on the same edge. An operation presented on that edge is discarded.
- Reset asserted while an operation's result is pending clears that result; no `out_valid` is produced for it.
- Operands and opcode may change every cycle. Only values present at a sampling edge matter.

## Configuration
- Macro: `DEVICE_ALU_REM_EN`.
- Defined: the divide result is `{remainder[3:0], quotient[3:0]}`.
  - Example: 7/2 gives 8'h13.
- Undefined: the divide result is `{4'h0, quotient[3:0]}`.
  - Example: 7/2 gives 8'h03.
- Divide-by-zero behaviour (8'hFF plus flag) is identical in both builds.

## Test plan
- Reset: hold `rst` high for 2 edges -> `out_data = 0`, `out_valid = 0`, `div_by_zero = 0`.
- Add: in1=2, in2=3, op=00, `in_valid` pulsed -> next cycle `out_data = 5`, `out_valid = 1`.
- Subtract:
  - in1=5, in2=3, op=01 -> `out_data = 2`.
  - in1=3, in2=5, op=01 -> `out_data = 8'hFE`.
- Multiply:
  - in1=2, in2=3, op=10 -> `out_data = 6`.
  - in1=15, in2=15, op=10 -> `out_data = 225`.
- Divide:
  - in1=6, in2=3, op=11 -> `out_data = 2` in both builds.
  - in1=7, in2=2, op=11 -> 8'h13 with `DEVICE_ALU_REM_EN` defined, 8'h03 without.
  - in1=9, in2=0, op=11 -> `out_data = 8'hFF`, `div_by_zero = 1`.
  - A following valid add clears `div_by_zero`.
- Hold and back-to-back:
  - Four consecutive valid ops -> four consecutive `out_valid` pulses with the correct results.
  - Then drop `in_valid` and change the operands -> outputs hold and `out_valid = 0`.
  - Assert `rst` on the same edge as `in_valid` -> outputs reset and no pulse.
